// File: rtl/bcd_interval_timer.sv
// bcd_interval_timer
//   Multi-digit BCD interval timer. It counts up from 0 to a loaded target,
//   or down from the target to 0. One count step happens every TICK_DIV
//   clocks. An internal prescaler produces a clock enable for this; no
//   derived clock is created.
//
// Ports
//   Clock, Reset       system clock, synchronous active-high reset
//   Load               capture Target_In, Mode_Down, Auto_Reload (level)
//   Start / Stop       start or resume / pause (Stop wins)
//   Mode_Down          0 = up to target, 1 = down from target to 0
//   Auto_Reload        restart after terminal count instead of stopping
//   Target_In          BCD target, digit 0 = LSD
//   Digit_Sel          digit shown on Digit_Out
//   Count_Out          current BCD count
//   Digit_Out          selected digit, 0 when Digit_Sel is out of range
//   Tick               one-cycle pulse per count step while running
//   Running            high in RUNNING
//   Time_Out           terminal-count flag (held in DONE, pulsed on reload)
//   Input_Error        last Load held a non-BCD digit (stored clamped to 9)
//
// state   | meaning
// IDLE    | after reset, no target loaded
// LOADED  | target captured, waiting for Start
// RUNNING | prescaler active, count steps on each tick
// PAUSED  | count and prescaler frozen, Start resumes
// DONE    | terminal count reached, Time_Out held until Load
module bcd_interval_timer #(
    parameter int NUM_DIGITS = 2,
    parameter int TICK_DIV   = 10_000_000,
    parameter int TICK_W     = 24,
    parameter int SEL_W      = 3
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Load,
    input  logic                    Start,
    input  logic                    Stop,
    input  logic                    Mode_Down,
    input  logic                    Auto_Reload,
    input  logic [4*NUM_DIGITS-1:0] Target_In,
    input  logic [SEL_W-1:0]        Digit_Sel,
    output logic [4*NUM_DIGITS-1:0] Count_Out,
    output logic [3:0]              Digit_Out,
    output logic                    Tick,
    output logic                    Running,
    output logic                    Time_Out,
    output logic                    Input_Error
);

    localparam int CW = 4 * NUM_DIGITS;

    typedef enum logic [2:0] {
        S_IDLE, S_LOADED, S_RUNNING, S_PAUSED, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   target_q, target_d;
    logic [TICK_W-1:0] presc_q, presc_d;
    logic            tick_q, tick_d;
    logic            time_out_q, time_out_d;
    logic            input_error_q, input_error_d;
    logic            mode_down_q, mode_down_d;
    logic            auto_reload_q, auto_reload_d;

    logic [CW-1:0]   target_clamped;
    logic            target_bad;
    logic [CW-1:0]   terminal;
    logic [CW-1:0]   reload_val;
    logic [CW-1:0]   count_step;
    logic            presc_wrap;

    // Ripple BCD increment: a digit at 9 wraps to 0 and carries onward.
    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Ripple BCD decrement: a digit at 0 wraps to 9 and borrows onward.
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        target_clamped = Target_In;
        target_bad     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (Target_In[4*i +: 4] > 4'd9) begin
                target_clamped[4*i +: 4] = 4'd9;
                target_bad               = 1'b1;
            end
        end
    end

    assign terminal   = mode_down_q ? '0 : target_q;
    assign reload_val = mode_down_q ? target_q : '0;
    assign count_step = mode_down_q ? bcd_dec(count_q) : bcd_inc(count_q);
    assign presc_wrap = (presc_q == TICK_W'(TICK_DIV - 1));

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        target_d      = target_q;
        presc_d       = presc_q;
        tick_d        = 1'b0;
        time_out_d    = time_out_q;
        input_error_d = input_error_q;
        mode_down_d   = mode_down_q;
        auto_reload_d = auto_reload_q;

        if (Load) begin
            state_d       = S_LOADED;
            target_d      = target_clamped;
            mode_down_d   = Mode_Down;
            auto_reload_d = Auto_Reload;
            presc_d       = '0;
            time_out_d    = 1'b0;
            input_error_d = target_bad;
            count_d       = Mode_Down ? target_clamped : '0;
        end else begin
            case (state_q)
                S_LOADED: begin
                    if (Start && !Stop) begin
                        // A zero target is already terminal in both modes.
                        if (target_q == '0) begin
                            state_d    = S_DONE;
                            time_out_d = 1'b1;
                        end else begin
                            state_d = S_RUNNING;
                        end
                    end
                end
                S_PAUSED: begin
                    if (Start && !Stop) state_d = S_RUNNING;
                end
                S_RUNNING: begin
                    // Time_Out is only a one-cycle pulse while running.
                    time_out_d = 1'b0;
                    if (Stop) begin
                        state_d = S_PAUSED;
                    end else if (presc_wrap) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (auto_reload_q && (count_q == terminal)) begin
                            // Terminal value was shown for one full tick period.
                            count_d = reload_val;
                        end else begin
                            count_d = count_step;
                            if (count_step == terminal) begin
                                time_out_d = 1'b1;
                                if (!auto_reload_q) state_d = S_DONE;
                            end
                        end
                    end else begin
                        presc_d = presc_q + TICK_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            target_q      <= '0;
            presc_q       <= '0;
            tick_q        <= 1'b0;
            time_out_q    <= 1'b0;
            input_error_q <= 1'b0;
            mode_down_q   <= 1'b0;
            auto_reload_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            target_q      <= target_d;
            presc_q       <= presc_d;
            tick_q        <= tick_d;
            time_out_q    <= time_out_d;
            input_error_q <= input_error_d;
            mode_down_q   <= mode_down_d;
            auto_reload_q <= auto_reload_d;
        end
    end

    always_comb begin
        Digit_Out = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (Digit_Sel == SEL_W'(i)) Digit_Out = count_q[4*i +: 4];
        end
    end

    assign Count_Out   = count_q;
    assign Tick        = tick_q;
    assign Running     = (state_q == S_RUNNING);
    assign Time_Out    = time_out_q;
    assign Input_Error = input_error_q;

endmodule

// File: tb/tb_bcd_interval_timer.sv
module tb_bcd_interval_timer;

    localparam int TICK_DIV = 4;

    logic       Clock = 1'b0;
    logic       Reset, Load, Start, Stop, Mode_Down, Auto_Reload;
    logic [7:0] Target_In;
    logic [2:0] Digit_Sel;
    logic [7:0] Count_Out;
    logic [3:0] Digit_Out;
    logic       Tick, Running, Time_Out, Input_Error;

    bcd_interval_timer #(
        .NUM_DIGITS(2), .TICK_DIV(TICK_DIV), .TICK_W(4), .SEL_W(3)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Load(Load), .Start(Start), .Stop(Stop),
        .Mode_Down(Mode_Down), .Auto_Reload(Auto_Reload), .Target_In(Target_In),
        .Digit_Sel(Digit_Sel), .Count_Out(Count_Out), .Digit_Out(Digit_Out),
        .Tick(Tick), .Running(Running), .Time_Out(Time_Out),
        .Input_Error(Input_Error)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] count;
        logic       time_out;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] target;
        logic       mode_down;
        logic [7:0] exp_count;
        logic       exp_err;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic push(input int v, input logic to);
        exp_t e;
        e.count    = bcd(v);
        e.time_out = to;
        sb.push_back(e);
    endtask

    task automatic do_load(input logic [7:0] t, input logic down, input logic auto_r);
        @(negedge Clock);
        Load = 1'b1; Target_In = t; Mode_Down = down; Auto_Reload = auto_r;
        @(negedge Clock);
        Load = 1'b0; Mode_Down = 1'b0; Auto_Reload = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    // Waits for n ticks, comparing each against the scoreboard head and the
    // spacing between ticks; first_gap is the expected wait to the first one.
    task automatic run_ticks(input int n, input int first_gap);
        int   cyc  = 0;
        int   got  = 0;
        int   last = 0;
        exp_t e;
        while (got < n && cyc < n * TICK_DIV + 20) begin
            @(negedge Clock);
            cyc++;
            if (Tick) begin
                if (sb.size() == 0) begin
                    check("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("tick_count", Count_Out, e.count);
                    check("tick_timeout", Time_Out, e.time_out);
                end
                check("tick_gap", cyc - last, (got == 0) ? first_gap : TICK_DIV);
                last = cyc;
                got++;
            end else begin
                check("idle_timeout", Time_Out, 1'b0);
            end
        end
        if (got < n) check("tick_budget", got, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks_seen;

        vecs[0] = '{8'h12, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'h12, 1'b1, 8'h12, 1'b0};
        vecs[2] = '{8'h1F, 1'b1, 8'h19, 1'b1};
        vecs[3] = '{8'hA5, 1'b1, 8'h95, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vecs[6] = '{8'h99, 1'b1, 8'h99, 1'b0};

        Reset = 1'b1; Load = 1'b0; Start = 1'b0; Stop = 1'b0;
        Mode_Down = 1'b0; Auto_Reload = 1'b0; Target_In = 8'h00; Digit_Sel = 3'd0;
        repeat (3) @(negedge Clock);
        check("reset_count", Count_Out, 8'h00);
        check("reset_running", Running, 1'b0);
        check("reset_timeout", Time_Out, 1'b0);
        check("reset_error", Input_Error, 1'b0);
        check("reset_tick", Tick, 1'b0);
        Reset = 1'b0;

        start_pulse();
        check("idle_start_ignored", Running, 1'b0);

        // Load vectors: captured count, BCD clamping, error flag, digit readout.
        for (int i = 0; i < 7; i++) begin
            do_load(vecs[i].target, vecs[i].mode_down, 1'b0);
            check("load_count", Count_Out, vecs[i].exp_count);
            check("load_error", Input_Error, vecs[i].exp_err);
            check("load_running", Running, 1'b0);
            Digit_Sel = 3'd0; #1;
            check("digit0", Digit_Out, vecs[i].exp_count[3:0]);
            Digit_Sel = 3'd1; #1;
            check("digit1", Digit_Out, vecs[i].exp_count[7:4]);
            Digit_Sel = 3'd2; #1;
            check("digit2_out_of_range", Digit_Out, 4'h0);
            Digit_Sel = 3'd7; #1;
            check("digit7_out_of_range", Digit_Out, 4'h0);
            Digit_Sel = 3'd0;
        end

        // Up count 00 -> 12, then DONE holds and ignores Start.
        do_load(8'h12, 1'b0, 1'b0);
        for (int v = 1; v <= 12; v++) push(v, v == 12);
        start_pulse();
        run_ticks(12, TICK_DIV);
        check("up_done_running", Running, 1'b0);
        check("up_done_timeout", Time_Out, 1'b1);
        repeat (8) @(negedge Clock);
        check("up_done_hold_count", Count_Out, 8'h12);
        check("up_done_hold_timeout", Time_Out, 1'b1);
        start_pulse();
        check("done_start_ignored", Running, 1'b0);

        // Down count 10 -> 00 across the borrow.
        do_load(8'h10, 1'b1, 1'b0);
        for (int v = 9; v >= 0; v--) push(v, v == 0);
        start_pulse();
        run_ticks(10, TICK_DIV);
        check("down_done_count", Count_Out, 8'h00);
        check("down_done_timeout", Time_Out, 1'b1);
        check("down_done_running", Running, 1'b0);

        // Pause at 05 with prescaler phase 1; Start+Stop keeps it paused.
        do_load(8'h12, 1'b0, 1'b0);
        for (int v = 1; v <= 5; v++) push(v, 1'b0);
        start_pulse();
        run_ticks(5, TICK_DIV);
        @(negedge Clock);
        Stop = 1'b1;
        ticks_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (Tick) ticks_seen++;
            check("pause_count", Count_Out, 8'h05);
            check("pause_running", Running, 1'b0);
            if (i == 8)  Start = 1'b1;
            if (i == 11) Start = 1'b0;
        end
        check("pause_no_tick", ticks_seen, 0);
        Stop = 1'b0;
        for (int v = 6; v <= 12; v++) push(v, v == 12);
        start_pulse();
        run_ticks(7, TICK_DIV - 1);
        check("resume_done_timeout", Time_Out, 1'b1);

        // Auto-reload with target 03.
        do_load(8'h03, 1'b0, 1'b1);
        push(1, 1'b0); push(2, 1'b0); push(3, 1'b1); push(0, 1'b0); push(1, 1'b0);
        start_pulse();
        run_ticks(5, TICK_DIV);
        check("auto_running", Running, 1'b1);

        // Zero target with auto-reload: straight to DONE, never reloads.
        do_load(8'h00, 1'b0, 1'b1);
        start_pulse();
        check("zero_timeout", Time_Out, 1'b1);
        check("zero_running", Running, 1'b0);
        ticks_seen = 0;
        repeat (10) begin
            @(negedge Clock);
            if (Tick) ticks_seen++;
        end
        check("zero_no_tick", ticks_seen, 0);
        check("zero_hold_timeout", Time_Out, 1'b1);
        check("zero_hold_count", Count_Out, 8'h00);

        // Load mid-run (with Start, Load wins), then Reset mid-run.
        do_load(8'h12, 1'b0, 1'b0);
        for (int v = 1; v <= 7; v++) push(v, 1'b0);
        start_pulse();
        run_ticks(7, TICK_DIV);
        @(negedge Clock);
        Load = 1'b1; Target_In = 8'h2A; Mode_Down = 1'b1; Start = 1'b1;
        @(negedge Clock);
        Load = 1'b0; Start = 1'b0; Mode_Down = 1'b0;
        check("reload_mid_count", Count_Out, 8'h29);
        check("reload_mid_running", Running, 1'b0);
        check("reload_mid_error", Input_Error, 1'b1);
        check("reload_mid_timeout", Time_Out, 1'b0);
        push(28, 1'b0); push(27, 1'b0);
        start_pulse();
        run_ticks(2, TICK_DIV);
        @(negedge Clock);
        Reset = 1'b1; Load = 1'b1; Start = 1'b1; Target_In = 8'h55;
        @(negedge Clock);
        Reset = 1'b0; Load = 1'b0; Start = 1'b0;
        check("midrun_reset_count", Count_Out, 8'h00);
        check("midrun_reset_running", Running, 1'b0);
        check("midrun_reset_tick", Tick, 1'b0);
        check("midrun_reset_timeout", Time_Out, 1'b0);
        check("midrun_reset_error", Input_Error, 1'b0);
        start_pulse();
        check("post_reset_idle_start", Running, 1'b0);

        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_interval_timer.md
Name: bcd_interval_timer

Overview:
- Parametrised multi-digit BCD interval timer. Successor to the fixed two-digit seconds timer.
- Generalised to NUM_DIGITS digits, with an internal tick prescaler (a clock enable rather than a derived clock).
- Adds up/down count modes, pause/resume, auto-reload, BCD input checking and a digit-select readout for a single 7-segment decoder.
- Sits between the switch/IO inputs and the seg7 decoder in the top-level wrapper.

Parameters:
- NUM_DIGITS, 2: number of BCD digits (1..8).
- TICK_DIV, 10_000_000: Clock cycles per count tick (>=2).
- TICK_W, 24: prescaler counter width; must hold TICK_DIV-1.
- SEL_W, 3: width of Digit_Sel.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Load  in  1  capture Target_In (level-sampled each cycle).
- Start  in  1  start or resume counting.
- Stop  in  1  pause counting.
- Mode_Down  in  1  0 = count 0 up to target; 1 = count target down to 0; sampled at Load.
- Auto_Reload  in  1  restart automatically at terminal count; sampled at Load.
- Target_In  in  4*NUM_DIGITS  BCD target, digit 0 = LSD.
- Digit_Sel  in  SEL_W  selects the digit shown on Digit_Out.
- Count_Out  out  4*NUM_DIGITS  current BCD count.
- Digit_Out  out  4  selected digit of Count_Out.
- Tick  out  1  one-cycle pulse on each count tick while running.
- Running  out  1  high in RUNNING state.
- Time_Out  out  1  terminal-count indication.
- Input_Error  out  1  last Load contained a non-BCD digit.

Behaviour:
- All state updates on the rising edge of Clock.
- Reset (synchronous, active-high) gives: state IDLE; Count_Out, target, prescaler, Tick, Running, Time_Out and Input_Error all 0; Mode_Down and Auto_Reload latches 0.
- Reset asserted mid-operation wins over every other input in that cycle.

States: IDLE, LOADED, RUNNING, PAUSED, DONE.

Load:
- Load=1 in any state goes to LOADED next cycle.
- Captures target, Mode_Down and Auto_Reload; clears the prescaler and Time_Out.
- Count_Out becomes target if Mode_Down=1, else 0.
- Any digit >9 is stored clamped to 9, and Input_Error is set.
- Input_Error is cleared by the next Load that has all digits valid.
- Load has priority over Start and Stop in the same cycle.

Start:
- LOADED or PAUSED, Start=1, Stop=0: go to RUNNING.
- The prescaler is not cleared on resume from PAUSED.
- Start in IDLE, RUNNING or DONE is ignored.

Stop:
- RUNNING and Stop=1: go to PAUSED; prescaler and count hold.
- Stop beats Start when both are asserted in the same cycle.

Prescaler and tick:
- Counts only in RUNNING.
- When it equals TICK_DIV-1, it wraps to 0 and Tick is 1 for that cycle.
- Count_Out updates on the same edge that registers Tick. Latency from Start to the first tick is TICK_DIV cycles.

Counting:
- Ripple BCD arithmetic: a digit wraps 9->0 (up) or 0->9 (down) and carries/borrows into the next digit.
- Terminal value is target (up mode) or 0 (down mode).
- On the tick that reaches terminal:
  - Auto_Reload=0: go to DONE; Time_Out=1 and held until Load or Reset; Count_Out holds the terminal value.
  - Auto_Reload=1: Count_Out holds the terminal value for one tick period with Time_Out pulsed for one cycle; on the next tick it reloads (up: 0, down: target) and stays RUNNING.

Zero target:
- Start from LOADED goes straight to DONE next cycle with Time_Out=1.
- This applies even when Auto_Reload=1; a zero target never reloads.

Outputs:
- Running = (state==RUNNING).
- Digit_Out is combinational: Count_Out digit[Digit_Sel], or 4'h0 when Digit_Sel >= NUM_DIGITS.
- No overflow is possible: count never exceeds target in up mode and never goes below 0 in down mode.

Test Plan:
(All scenarios use NUM_DIGITS=2, TICK_DIV=4.)
- Reset then Load 8'h12, up, Start -> Tick every 4 cycles; Count_Out 00,01,...,09,10,11,12; Time_Out=1 at 12; state DONE; count holds.
- Load 8'h10, Mode_Down=1, Start -> Count_Out 10,09,...,00; borrow 10->09 correct; Time_Out=1 at 00.
- Running at count 05: Stop for 20 cycles, then Start -> count frozen at 05, no Tick while paused; next tick occurs at the remaining prescaler phase; Start+Stop together keeps PAUSED.
- Load 8'h03, Auto_Reload=1, up -> sequence 01,02,03,00,01... ; Time_Out one-cycle pulse at each 03; Running stays 1.
- Load 8'h1F -> Input_Error=1, target 19. Load 8'h00, Start -> DONE next cycle, Time_Out=1. Digit_Sel=2 -> Digit_Out=0.
- Load mid-run at count 07, then Reset asserted mid-run -> Load restarts at LOADED with new target; Reset gives all outputs 0 and IDLE on the next edge.
